ct_spsram_ctrl: RTL and testbench

Request-side controller for a single-port SRAM macro with active-low CEN, GWEN and per-bit WEN, and a 1-cycle read latency. After reset it sweeps the whole array to a known value. It then accepts read and write requests over a valid/ready handshake, drives the macro pins and returns read data through a 2-entry response buffer with backpressure. It sits between IFU table logic and the SRAM instance.

---
 rtl/ct_spsram_ctrl_pkg.sv | 15 +
 rtl/ct_spsram_ctrl_rsp_fifo.sv | 63 ++++++
 rtl/ct_spsram_ctrl.sv | 125 ++++++++++++
 tb/tb_ct_spsram_ctrl.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ct_spsram_ctrl_pkg.sv
// Shared types and constants for the single-port SRAM request controller.
// Holds the FSM state enum, the response buffer depth and the idle pin levels.
package ct_spsram_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RESET = 2'd0,
        ST_INIT  = 2'd1,
        ST_RUN   = 2'd2
    } state_e;

    localparam int   RSP_DEPTH = 2;
    localparam logic CEN_OFF   = 1'b1;
    localparam logic GWEN_OFF  = 1'b1;

endpackage

// File: rtl/ct_spsram_ctrl_rsp_fifo.sv
// 2-entry in-order read response buffer; head is visible the cycle after a push.
// Push is honoured when not full or when a pop happens in the same cycle.
module ct_spsram_ctrl_rsp_fifo
    import ct_spsram_ctrl_pkg::*;
#(
    parameter int DW = 59
) (
    input  logic          clk,
    input  logic          rst_b,
    input  logic          push,
    input  logic [DW-1:0] push_dat,
    input  logic          pop,
    output logic [DW-1:0] head_dat,
    output logic          full,
    output logic          empty,
    output logic [1:0]    count
);

    logic [DW-1:0] mem_q [RSP_DEPTH];
    logic [DW-1:0] mem_d [RSP_DEPTH];
    logic          wr_ptr_q, wr_ptr_d;
    logic          rd_ptr_q, rd_ptr_d;
    logic [1:0]    cnt_q, cnt_d;
    logic          pop_ok, push_ok;

    always_comb begin
        pop_ok   = pop & (cnt_q != 2'd0);
        push_ok  = push & ((cnt_q != 2'(RSP_DEPTH)) | pop_ok);
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = push_dat;
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (pop_ok) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        cnt_d = cnt_q + {1'b0, push_ok} - {1'b0, pop_ok};
    end

    always_ff @(posedge clk) begin
        if (!rst_b) begin
            for (int i = 0; i < RSP_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            cnt_q    <= 2'd0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    assign head_dat = mem_q[rd_ptr_q];
    assign full     = (cnt_q == 2'(RSP_DEPTH));
    assign empty    = (cnt_q == 2'd0);
    assign count    = cnt_q;

endmodule

// File: rtl/ct_spsram_ctrl.sv
// Single-port SRAM controller: init sweep after reset, then valid/ready reads and writes.
// Read response 2 cycles after accept; req_rdy drops once 2 responses are owed and unpopped.
module ct_spsram_ctrl
    import ct_spsram_ctrl_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 9,
    parameter int                    DATA_WIDTH = 59,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
    input  logic                  forever_cpuclk,
    input  logic                  cpurst_b,
    input  logic                  req_vld,
    output logic                  req_rdy,
    input  logic                  req_wr,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    input  logic [DATA_WIDTH-1:0] req_bmask,
    output logic                  rsp_vld,
    input  logic                  rsp_rdy,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  init_done,
    output logic [ADDR_WIDTH-1:0] sram_a,
    output logic                  sram_cen,
    output logic                  sram_gwen,
    output logic [DATA_WIDTH-1:0] sram_wen,
    output logic [DATA_WIDTH-1:0] sram_d,
    input  logic [DATA_WIDTH-1:0] sram_q
);

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] init_cnt_q, init_cnt_d;
    logic                  init_done_q, init_done_d;
    logic                  inflight_q, inflight_d;

    logic [DATA_WIDTH-1:0] fifo_head;
    logic                  fifo_full, fifo_empty;
    logic [1:0]            fifo_cnt;
    logic                  rsp_pop, acc;
    logic [2:0]            occ;

    always_comb begin
        rsp_pop = ~fifo_empty & rsp_rdy;
        // A pop in this cycle frees its slot for a read accepted now, which keeps
        // back-to-back reads bubble-free while rsp_rdy stays high.
        occ     = {1'b0, fifo_cnt} + {2'b0, inflight_q} - {2'b0, rsp_pop};
        req_rdy = (state_q == ST_RUN) && (occ < 3'(RSP_DEPTH));
        acc     = req_vld & req_rdy;

        state_d     = state_q;
        init_cnt_d  = init_cnt_q;
        init_done_d = init_done_q;
        inflight_d  = acc & ~req_wr;

        case (state_q)
            ST_RESET: state_d = ST_INIT;
            ST_INIT: begin
                init_cnt_d = init_cnt_q + ADDR_WIDTH'(1);
                if (init_cnt_q == '1) begin
                    state_d     = ST_RUN;
                    init_done_d = 1'b1;
                end
            end
            default: ;
        endcase

        sram_cen  = CEN_OFF;
        sram_gwen = GWEN_OFF;
        sram_wen  = '1;
        sram_a    = req_addr;
        sram_d    = req_wdata;
        if (state_q == ST_INIT) begin
            sram_cen  = 1'b0;
            sram_gwen = 1'b0;
            sram_wen  = '0;
            sram_a    = init_cnt_q;
            sram_d    = INIT_VALUE;
        end else if (acc) begin
            sram_cen = 1'b0;
            if (req_wr) begin
                sram_gwen = 1'b0;
                sram_wen  = ~req_bmask;
            end
        end
    end

    always_ff @(posedge forever_cpuclk) begin
        if (!cpurst_b) begin
            state_q     <= ST_RESET;
            init_cnt_q  <= '0;
            init_done_q <= 1'b0;
            inflight_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            init_cnt_q  <= init_cnt_d;
            init_done_q <= init_done_d;
            inflight_q  <= inflight_d;
        end
    end

    // The returning read must always find room in the buffer.
    always_ff @(posedge forever_cpuclk) begin
        if (cpurst_b) begin
            assert (!(fifo_full && inflight_q && !rsp_pop));
        end
    end

    ct_spsram_ctrl_rsp_fifo #(
        .DW (DATA_WIDTH)
    ) u_rsp_fifo (
        .clk      (forever_cpuclk),
        .rst_b    (cpurst_b),
        .push     (inflight_q),
        .push_dat (sram_q),
        .pop      (rsp_pop),
        .head_dat (fifo_head),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_cnt)
    );

    assign rsp_vld   = ~fifo_empty;
    assign rsp_rdata = fifo_head;
    assign init_done = init_done_q;

endmodule

// File: tb/tb_ct_spsram_ctrl.sv
// Bench for ct_spsram_ctrl: behavioural SRAM macro plus an array/queue reference model.
module tb_ct_spsram_ctrl;

    localparam int AW    = 9;
    localparam int DW    = 59;
    localparam int DEPTH = 1 << AW;
    typedef logic [DW-1:0] word_t;
    localparam word_t INIT_V = 59'h0A5_0F0F_1234_5678;

    logic          forever_cpuclk = 1'b0;
    logic          cpurst_b       = 1'b0;
    logic          req_vld        = 1'b0;
    logic          req_wr         = 1'b0;
    logic          rsp_rdy        = 1'b0;
    logic [AW-1:0] req_addr       = '0;
    word_t         req_wdata      = '0;
    word_t         req_bmask      = '0;
    logic          req_rdy, rsp_vld, init_done, sram_cen, sram_gwen;
    logic [AW-1:0] sram_a;
    word_t         rsp_rdata, sram_wen, sram_d;
    word_t         sram_q         = '0;

    int total = 0;
    int bad   = 0;

    ct_spsram_ctrl #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .INIT_VALUE (INIT_V)
    ) dut (
        .forever_cpuclk (forever_cpuclk),
        .cpurst_b       (cpurst_b),
        .req_vld        (req_vld),
        .req_rdy        (req_rdy),
        .req_wr         (req_wr),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .req_bmask      (req_bmask),
        .rsp_vld        (rsp_vld),
        .rsp_rdy        (rsp_rdy),
        .rsp_rdata      (rsp_rdata),
        .init_done      (init_done),
        .sram_a         (sram_a),
        .sram_cen       (sram_cen),
        .sram_gwen      (sram_gwen),
        .sram_wen       (sram_wen),
        .sram_d         (sram_d),
        .sram_q         (sram_q)
    );

    always #5 forever_cpuclk = ~forever_cpuclk;

    // Behavioural macro: per-bit masked write, registered read data.
    word_t macro_mem [DEPTH];
    always @(posedge forever_cpuclk) begin
        if (!sram_cen) begin
            if (!sram_gwen) macro_mem[sram_a] <= (macro_mem[sram_a] & sram_wen) | (sram_d & ~sram_wen);
            else            sram_q <= macro_mem[sram_a];
        end
    end

    // Reference model: expected array contents, owed responses and their accept cycles.
    word_t ref_mem [DEPTH];
    word_t exp_dat_q [$];
    int    exp_cyc_q [$];
    int    cyc       = 0;
    int    rel_edges = -1;

    task automatic chk(input string tag, input word_t got, input word_t exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic word_t rnd_word();
        logic [63:0] t;
        t = {$urandom(), $urandom()};
        return t[DW-1:0];
    endfunction

    task automatic run_cycle(input logic rst, input logic vld, input logic wr,
                             input logic [AW-1:0] addr, input word_t wdata,
                             input word_t bmask, input logic rrdy, output logic acc);
        logic  run, exp_vld, exp_rdy, pop;
        int    owed;
        word_t dummy;
        int    dummy_c;
        cpurst_b  = rst;
        req_vld   = vld;
        req_wr    = wr;
        req_addr  = addr;
        req_wdata = wdata;
        req_bmask = bmask;
        rsp_rdy   = rrdy;
        #2;
        run     = (rel_edges >= DEPTH);
        exp_vld = (exp_dat_q.size() > 0) && (exp_cyc_q[0] <= cyc - 2);
        pop     = exp_vld && rrdy;
        owed    = exp_dat_q.size() - (pop ? 1 : 0);
        exp_rdy = run && (owed < 2);
        acc     = vld && exp_rdy;

        chk("init_done", word_t'(init_done), word_t'(run));
        chk("req_rdy", word_t'(req_rdy), word_t'(exp_rdy));
        chk("rsp_vld", word_t'(rsp_vld), word_t'(exp_vld));
        if (exp_vld) chk("rsp_rdata", rsp_rdata, exp_dat_q[0]);
        if (rel_edges < 0) chk("rst_rdata", rsp_rdata, '0);

        if (rel_edges >= 0 && !run) begin
            chk("init_cen", word_t'(sram_cen), '0);
            chk("init_gwen", word_t'(sram_gwen), '0);
            chk("init_wen", sram_wen, '0);
            chk("init_a", word_t'(sram_a), word_t'(rel_edges));
            chk("init_d", sram_d, INIT_V);
        end else if (acc) begin
            chk("acc_cen", word_t'(sram_cen), '0);
            chk("acc_a", word_t'(sram_a), word_t'(addr));
            chk("acc_gwen", word_t'(sram_gwen), word_t'(!wr));
            chk("acc_wen", sram_wen, wr ? ~bmask : '1);
            if (wr) chk("acc_d", sram_d, wdata);
        end else begin
            chk("idle_cen", word_t'(sram_cen), word_t'(1'b1));
            chk("idle_gwen", word_t'(sram_gwen), word_t'(1'b1));
            chk("idle_wen", sram_wen, '1);
        end

        if (pop) begin
            dummy   = exp_dat_q.pop_front();
            dummy_c = exp_cyc_q.pop_front();
        end
        if (acc && wr) ref_mem[addr] = (ref_mem[addr] & ~bmask) | (wdata & bmask);
        if (acc && !wr) begin
            exp_dat_q.push_back(ref_mem[addr]);
            exp_cyc_q.push_back(cyc);
        end

        @(posedge forever_cpuclk);
        cyc++;
        if (!rst) begin
            rel_edges = -1;
            exp_dat_q.delete();
            exp_cyc_q.delete();
        end else begin
            rel_edges++;
            if (rel_edges == DEPTH) begin
                for (int i = 0; i < DEPTH; i++) ref_mem[i] = INIT_V;
            end
        end
        @(negedge forever_cpuclk);
    endtask

    task automatic idle(input int n);
        logic a;
        for (int i = 0; i < n; i++) run_cycle(1'b1, 1'b0, 1'b0, '0, '0, '0, 1'b1, a);
    endtask

    task automatic issue(input logic wr, input logic [AW-1:0] addr, input word_t wdata, input word_t bmask);
        logic a;
        int   n;
        n = 0;
        do begin
            run_cycle(1'b1, 1'b1, wr, addr, wdata, bmask, 1'b1, a);
            n++;
        end while (!a && n < 50);
        chk("issue_acc", word_t'(a), word_t'(1'b1));
    endtask

    logic a_m;
    int   n_m, k_m, acc_bp;

    initial begin
        for (int i = 0; i < DEPTH; i++) macro_mem[i] = rnd_word();
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
        repeat (3) @(posedge forever_cpuclk);
        @(negedge forever_cpuclk);

        // Reset values with a request presented.
        run_cycle(1'b0, 1'b1, 1'b0, 9'd5, '0, '0, 1'b1, a_m);

        // Start the sweep, interrupt it at address 200 for one cycle.
        n_m = 0;
        while (rel_edges < 200 && n_m < 1000) begin
            run_cycle(1'b1, 1'b0, 1'b0, '0, '0, '0, 1'b1, a_m);
            n_m++;
        end
        chk("sweep_at_200", word_t'(rel_edges), word_t'(200));
        run_cycle(1'b0, 1'b0, 1'b0, '0, '0, '0, 1'b1, a_m);

        // Release; init_done must rise exactly DEPTH cycles after the release edge.
        run_cycle(1'b1, 1'b0, 1'b0, '0, '0, '0, 1'b1, a_m);
        n_m = 0;
        while (!init_done && n_m < 600) begin
            run_cycle(1'b1, 1'b0, 1'b0, '0, '0, '0, 1'b1, a_m);
            n_m++;
        end
        chk("init_latency", word_t'(n_m), word_t'(DEPTH));

        issue(1'b0, 9'd0, '0, '0);
        issue(1'b0, 9'd255, '0, '0);
        issue(1'b0, 9'd511, '0, '0);
        idle(4);

        issue(1'b1, 9'h10, 59'h5A5A5A5A5A5A5A5, '1);
        issue(1'b0, 9'h10, '0, '0);
        idle(4);

        issue(1'b1, 9'd3, '1, '1);
        issue(1'b1, 9'd3, '0, 59'h00000000000000F);
        issue(1'b0, 9'd3, '0, '0);
        idle(4);

        // Backpressure: four reads with rsp_rdy low for the first 6 cycles.
        for (int i = 0; i < 4; i++) issue(1'b1, AW'(20 + i), rnd_word(), '1);
        k_m    = 0;
        acc_bp = 0;
        for (int t = 0; t < 60 && k_m < 4; t++) begin
            run_cycle(1'b1, 1'b1, 1'b0, AW'(20 + k_m), '0, '0, (t >= 6), a_m);
            if (a_m) begin
                k_m++;
                if (t < 6) acc_bp++;
            end
        end
        chk("bp_accepts", word_t'(acc_bp), word_t'(2));
        chk("bp_all_reads", word_t'(k_m), word_t'(4));
        idle(4);

        // Streaming: 16 consecutive reads, no bubbles.
        for (int i = 0; i < 16; i++) issue(1'b1, AW'(32 + i), rnd_word(), '1);
        idle(3);
        n_m = 0;
        for (int i = 0; i < 16; i++) begin
            run_cycle(1'b1, 1'b1, 1'b0, AW'(32 + i), '0, '0, 1'b1, a_m);
            if (a_m) n_m++;
        end
        chk("stream_accepts", word_t'(n_m), word_t'(16));
        idle(4);

        // Random traffic over a narrow address window to provoke read-after-write.
        for (int i = 0; i < 2000; i++) begin
            run_cycle(1'b1, ($urandom % 4) != 0, $urandom % 2,
                      (($urandom % 8) == 0) ? AW'($urandom % DEPTH) : AW'($urandom % 16),
                      rnd_word(), rnd_word(), ($urandom % 4) != 0, a_m);
        end
        idle(8);
        chk("drained", word_t'(exp_dat_q.size()), '0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
